// File: rtl/mult_rr_arbiter_if.sv
// Request, multiplier and response bus of the shared-multiplier arbiter.
// slave = arbiter side, master = requesters / multiplier / consumer side.
`timescale 1ns/1ps
interface mult_rr_arbiter_if #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_a;
  logic [NUM_REQ*BIT_WIDTH-1:0] req_b;
  logic [BIT_WIDTH-1:0]         mult_a;
  logic [BIT_WIDTH-1:0]         mult_b;
  logic [BIT_WIDTH-1:0]         mult_y;
  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [BIT_WIDTH-1:0]         rsp_y;

  modport slave (
    input  req_valid, req_a, req_b, mult_y,
    output req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_y
  );

  modport master (
    output req_valid, req_a, req_b, mult_y,
    input  req_ready, mult_a, mult_b, rsp_valid, rsp_id, rsp_y
  );
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier among NUM_REQ requesters.
// Define MULT_ARB_STATS_EN to add per-requester saturating grant counters (stat_cnt/stat_clr).
`timescale 1ns/1ps
module mult_rr_arbiter #(
  parameter int BIT_WIDTH    = 16,
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int MULT_LATENCY = 2,
  parameter int Q            = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arb_en,
  mult_rr_arbiter_if.slave    bus,
  output logic                busy
`ifdef MULT_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [NUM_REQ*16-1:0] stat_cnt
`endif
);

  if (ID_W != $clog2(NUM_REQ) || MULT_LATENCY < 1 || Q >= BIT_WIDTH) begin : g_param_err
    $error("mult_rr_arbiter: inconsistent parameters");
  end

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[ID_W-1:0];
  endfunction

  logic [ID_W-1:0]          last_ptr;
  logic [ID_W-1:0]          cand;
  logic                     grant_any;
  logic [ID_W-1:0]          grant_id;
  logic [NUM_REQ-1:0]       grant_oh;
  logic signed [BIT_WIDTH-1:0] a_sel, b_sel;
  logic signed [BIT_WIDTH-1:0] a_hold, b_hold;

  // Grant stage: circular search starting just after the last winner
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_idx(last_ptr, k);
      if (!grant_any && arb_en && rst_n && bus.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (grant_any) grant_oh[grant_id] = 1'b1;
  end

  assign bus.req_ready = grant_oh;
  assign a_sel = bus.req_a[int'(grant_id)*BIT_WIDTH +: BIT_WIDTH];
  assign b_sel = bus.req_b[int'(grant_id)*BIT_WIDTH +: BIT_WIDTH];

  // Operands go out combinationally on a grant; idle cycles replay the last pair
  assign bus.mult_a = grant_any ? a_sel : a_hold;
  assign bus.mult_b = grant_any ? b_sel : b_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr <= ID_W'(NUM_REQ - 1);
      a_hold   <= '0;
      b_hold   <= '0;
    end else begin
      if (grant_any) last_ptr <= grant_id;
      a_hold <= bus.mult_a;
      b_hold <= bus.mult_b;
    end
  end

  // Tag pipe p0..p(MULT_LATENCY-1): travels in lockstep with the multiplier
  logic [MULT_LATENCY-1:0] vld_p;
  logic [ID_W-1:0]         id_p [MULT_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < MULT_LATENCY; i++) id_p[i] <= '0;
    end else begin
      vld_p[0] <= grant_any;
      id_p[0]  <= grant_id;
      for (int i = 1; i < MULT_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  assign bus.rsp_valid = vld_p[MULT_LATENCY-1];
  assign bus.rsp_id    = id_p[MULT_LATENCY-1];
  assign bus.rsp_y     = bus.mult_y;
  assign busy          = |vld_p;

`ifdef MULT_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (grant_any) begin
      cnt[grant_id] <= sat_inc(cnt[grant_id]);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_cnt[g*16 +: 16] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with a Q10 two-stage multiplier stand-in.
`timescale 1ns/1ps
module tb_mult_rr_arbiter;
  localparam int BW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic arb_en;
  logic busy;
  int   checks = 0;
  int   failures = 0;

  mult_rr_arbiter_if #(.BIT_WIDTH(BW), .NUM_REQ(NR), .ID_W(IW)) bus ();

`ifdef MULT_ARB_STATS_EN
  logic            stat_clr;
  logic [NR*16-1:0] stat_cnt;
`endif

  mult_rr_arbiter #(
    .BIT_WIDTH(BW), .NUM_REQ(NR), .ID_W(IW), .MULT_LATENCY(2), .Q(10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .bus     (bus.slave),
    .busy    (busy)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Q10 multiplier stand-in, latency 2
  logic signed [31:0] prod;
  logic [BW-1:0]      y_p1, y_p2;
  assign prod = $signed(bus.mult_a) * $signed(bus.mult_b);
  always_ff @(posedge clk) begin
    y_p1 <= prod[25:10];
    y_p2 <= y_p1;
  end
  assign bus.mult_y = y_p2;

  logic [15:0] y_exp [4] = '{16'h0800, 16'h0C00, 16'h1400, 16'hF800};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    arb_en = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a = '0;
    bus.req_b = '0;
`ifdef MULT_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    #12;
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mult_a", 32'(bus.mult_a), 0);
    check("rst_mult_b", 32'(bus.mult_b), 0);

    // single request from requester 2: 1.5 * 2.0
    tick();
    rst_n = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_a[2*BW +: BW] = 16'h0600;
    bus.req_b[2*BW +: BW] = 16'h0800;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h4);
    check("single_mult_a", 32'(bus.mult_a), 32'h0600);
    check("single_mult_b", 32'(bus.mult_b), 32'h0800);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    check("single_idle_ready", 32'(bus.req_ready), 0);
    check("single_hold_a", 32'(bus.mult_a), 32'h0600);
    check("single_t1_busy", 32'(busy), 1);
    check("single_t1_valid", 32'(bus.rsp_valid), 0);
    tick();
    check("single_t2_valid", 32'(bus.rsp_valid), 1);
    check("single_t2_id", 32'(bus.rsp_id), 2);
    check("single_t2_y", 32'(bus.rsp_y), 32'h0C00);
    tick();
    check("single_t3_valid", 32'(bus.rsp_valid), 0);
    check("single_t3_busy", 32'(busy), 0);

    // reset from idle, then full load in rotation
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check("rst2_mult_a", 32'(bus.mult_a), 0);
    bus.req_a = {16'hFC00, 16'h0A00, 16'h0600, 16'h0400};
    bus.req_b = {16'h0800, 16'h0800, 16'h0800, 16'h0800};
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("full_ready_%0d", k), 32'(bus.req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        check($sformatf("full_valid_%0d", k), 32'(bus.rsp_valid), 1);
        check($sformatf("full_id_%0d", k), 32'(bus.rsp_id), 32'((k - 2) % 4));
        check($sformatf("full_y_%0d", k), 32'(bus.rsp_y), 32'(y_exp[(k - 2) % 4]));
      end else begin
        check($sformatf("full_valid_%0d", k), 32'(bus.rsp_valid), 0);
      end
      if (k >= 1) check($sformatf("full_busy_%0d", k), 32'(busy), 1);
      tick();
    end

    // arb_en drop: exactly two drain responses (ids 2, 3)
    arb_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      check($sformatf("drain_ready_%0d", j), 32'(bus.req_ready), 0);
      check($sformatf("drain_valid_%0d", j), 32'(bus.rsp_valid), 32'(j < 2));
      if (j < 2) check($sformatf("drain_id_%0d", j), 32'(bus.rsp_id), 32'(j + 2));
      check($sformatf("drain_busy_%0d", j), 32'(busy), 32'(j < 2));
      tick();
    end

    // reset with two ops in flight
    arb_en = 1'b1;
    #1;
    check("inflight_g0", 32'(bus.req_ready), 32'h1);
    tick();
    check("inflight_g1", 32'(bus.req_ready), 32'h2);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.rsp_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ready", 32'(bus.req_ready), 0);
    check("arst_id", 32'(bus.rsp_id), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_g0", 32'(bus.req_ready), 32'h1);
    check("post_rst_valid0", 32'(bus.rsp_valid), 0);
    tick();
    check("post_rst_g1", 32'(bus.req_ready), 32'h2);
    check("post_rst_valid1", 32'(bus.rsp_valid), 0);
    tick();

    // only 1 and 3 requesting with last_ptr=1
    bus.req_valid = 4'b1010;
    #1;
    check("odd_g3a", 32'(bus.req_ready), 32'h8);
    check("fresh_valid", 32'(bus.rsp_valid), 1);
    check("fresh_id", 32'(bus.rsp_id), 0);
    tick();
    check("odd_g1", 32'(bus.req_ready), 32'h2);
    check("fresh_id1", 32'(bus.rsp_id), 1);
    tick();
    check("odd_g3b", 32'(bus.req_ready), 32'h8);
    tick();

    // lone requester wins every cycle, including across the pointer wrap
    bus.req_valid = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      #1;
      check($sformatf("lone_ready_%0d", j), 32'(bus.req_ready), 32'h1);
      tick();
    end
    bus.req_valid = 4'b0000;
    #1;
    check("drop_ready", 32'(bus.req_ready), 0);
    check("drop_hold_a", 32'(bus.mult_a), 32'h0400);

`ifdef MULT_ARB_STATS_EN
    bus.req_valid = 4'b0001;
    repeat (70000) tick();
    check("stat_sat", 32'(stat_cnt[15:0]), 32'hFFFF);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    check("stat_clr", 32'(stat_cnt[15:0]), 0);
    tick();
    check("stat_after_clr", 32'(stat_cnt[15:0]), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
